// File: rtl/router_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | router_pkg : shared constants, tx FSM states and FIFO entry tag layout  |
// | Revision   : 1.0                                                        |
// +-------------------------------------------------------------------------+
package router_pkg;

  localparam int NUM_PORTS   = 16;
  localparam int ADDR_W      = 4;
  localparam int DEFAULT_PAD = 5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PORT = 3'd1,
    ADDR      = 3'd2,
    PAD       = 3'd3,
    DATA      = 3'd4,
    STALL     = 3'd5,
    DONE      = 3'd6
  } tx_state_e;

  // Upper part of a FIFO entry; the payload word is appended below it.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
  } tx_tag_t;

  localparam int TAG_W = $bits(tx_tag_t);

endpackage
`default_nettype wire

// File: rtl/router_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | router_tx_fifo : synchronous FIFO, wrap-bit pointers, show-ahead head   |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module router_tx_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop && !empty) rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_port_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | router_port_tx : byte stream -> router bit-serial din/valid_n/frame_n    |
// | Option         : ROUTER_TX_STATS_EN enables pkt_count/byte_count        |
// | Revision       : 1.0                                                    |
// +-------------------------------------------------------------------------+
module router_port_tx
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int PAD_CYCLES = DEFAULT_PAD,
  parameter int DATA_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic [ADDR_W-1:0]    s_addr,
  input  logic [NUM_PORTS-1:0] dst_busy_n,
  output logic                 din,
  output logic                 valid_n,
  output logic                 frame_n,
  output logic                 tx_active,
  output logic                 pkt_done,
  output logic [15:0]          pkt_count,
  output logic [15:0]          byte_count
);

  localparam int ENTRY_W  = TAG_W + DATA_W;
  localparam int LVL_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_MAX0 = (PAD_CYCLES > DATA_W) ? PAD_CYCLES : DATA_W;
  localparam int CNT_MAX  = (CNT_MAX0 > ADDR_W) ? CNT_MAX0 : ADDR_W;
  localparam int CNT_W    = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] PAD_LAST  = CNT_W'(PAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [LVL_W-1:0]   w_level;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  tx_tag_t            w_head_tag;
  logic [DATA_W-1:0]  w_head_data;
  logic [DATA_W-1:0]  w_data_sh;
  logic               w_more;

  tx_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]  addr_sh_q;
  logic               din_q;
  logic               valid_n_q;
  logic               frame_n_q;
  logic               tx_active_q;
  logic               pkt_done_q;

  assign s_ready     = !w_full;
  assign w_push      = s_valid && !w_full;
  assign w_wdata     = {s_addr, s_last, s_data};
  assign w_head_tag  = w_rdata[ENTRY_W-1 -: TAG_W];
  assign w_head_data = w_rdata[DATA_W-1:0];
  assign w_data_sh   = w_head_data >> cnt_q;
  assign w_pop       = (state_q == DATA) && (cnt_q == DATA_LAST);
  // Another entry is available right after the current one retires.
  assign w_more      = (w_level > LVL_W'(1)) || w_push;

  router_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Serial outputs default to idle each cycle; each state overrides what it drives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_sh_q   <= '0;
      din_q       <= 1'b0;
      valid_n_q   <= 1'b1;
      frame_n_q   <= 1'b1;
      tx_active_q <= 1'b0;
      pkt_done_q  <= 1'b0;
    end else begin
      din_q       <= 1'b0;
      valid_n_q   <= 1'b1;
      frame_n_q   <= 1'b1;
      tx_active_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!w_empty) state_q <= WAIT_PORT;
        end
        WAIT_PORT: begin
          addr_sh_q <= w_head_tag.addr;
          if (dst_busy_n[w_head_tag.addr]) begin
            cnt_q   <= '0;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          din_q       <= addr_sh_q[0];
          frame_n_q   <= 1'b0;
          tx_active_q <= 1'b1;
          addr_sh_q   <= addr_sh_q >> 1;
          if (cnt_q == ADDR_LAST) begin
            cnt_q   <= '0;
            state_q <= PAD;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PAD: begin
          din_q       <= 1'b1;
          frame_n_q   <= 1'b0;
          tx_active_q <= 1'b1;
          if (cnt_q == PAD_LAST) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          din_q       <= w_data_sh[0];
          valid_n_q   <= 1'b0;
          frame_n_q   <= 1'b0;
          tx_active_q <= 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_q <= '0;
            if (w_head_tag.last) begin
              frame_n_q <= 1'b1;
              state_q   <= DONE;
            end else if (!w_more) begin
              state_q <= STALL;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STALL: begin
          din_q       <= 1'b1;
          frame_n_q   <= 1'b0;
          tx_active_q <= 1'b1;
          if (!w_empty) state_q <= DATA;
        end
        DONE: begin
          pkt_done_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din       = din_q;
  assign valid_n   = valid_n_q;
  assign frame_n   = frame_n_q;
  assign tx_active = tx_active_q;
  assign pkt_done  = pkt_done_q;

`ifdef ROUTER_TX_STATS_EN
  logic [15:0] pkt_count_q;
  logic [15:0] byte_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_q  <= '0;
      byte_count_q <= '0;
    end else begin
      if (state_q == DONE) pkt_count_q <= pkt_count_q + 16'd1;
      if (w_pop) byte_count_q <= byte_count_q + 16'd1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign byte_count = byte_count_q;
`else
  assign pkt_count  = '0;
  assign byte_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_router_port_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------------+
// | tb_router_port_tx : directed + randomized bench with a frame decoder    |
// | Revision          : 1.0                                                 |
// +-------------------------------------------------------------------------+
module tb_router_port_tx;

  localparam int PAD    = 5;
  localparam int FRAME1 = 4 + PAD + 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [3:0]  s_addr;
  logic [15:0] dst_busy_n;
  logic        din;
  logic        valid_n;
  logic        frame_n;
  logic        tx_active;
  logic        pkt_done;
  logic [15:0] pkt_count;
  logic [15:0] byte_count;

  int n_cmp = 0;
  int n_err = 0;

  router_port_tx #(
    .FIFO_DEPTH (8),
    .PAD_CYCLES (PAD),
    .DATA_W     (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_addr     (s_addr),
    .dst_busy_n (dst_busy_n),
    .din        (din),
    .valid_n    (valid_n),
    .frame_n    (frame_n),
    .tx_active  (tx_active),
    .pkt_done   (pkt_done),
    .pkt_count  (pkt_count),
    .byte_count (byte_count)
  );

  always #5 clock = ~clock;

  // Reference model: bytes in acceptance order, consumed as frames complete.
  logic [7:0] exp_bytes [$];

  // Frame decoder: turns the serial wire activity into per-frame records.
  logic [3:0] fr_addr   [$];
  int         fr_len    [$];
  int         fr_nbytes [$];
  int         fr_stall  [$];
  int         fr_fnlow  [$];
  int         fr_vlow   [$];
  logic       fr_ok     [$];
  logic [7:0] rx_bytes  [$];
  logic [7:0] cur_bytes [$];
  logic [3:0] cur_addr;
  logic [7:0] cur_byte;
  logic       in_frame = 1'b0;
  logic       bad = 1'b0;
  logic       last_fn = 1'b1;
  int         n_cyc = 0, bitn = 0, stall = 0, fnlow = 0, vlow = 0;
  int         idle_bad = 0;
  int         fr_idx = 0, rx_idx = 0;

  always @(negedge clock) begin
    if (reset) begin
      in_frame = 1'b0; n_cyc = 0; bitn = 0; stall = 0; fnlow = 0; vlow = 0;
      bad = 1'b0; cur_bytes.delete();
    end else if (tx_active) begin
      in_frame = 1'b1;
      if (n_cyc < 4) begin
        cur_addr = {din, cur_addr[3:1]};
        if (!valid_n) bad = 1'b1;
      end else if (n_cyc < 4 + PAD) begin
        if (!din || !valid_n) bad = 1'b1;
      end else if (!valid_n) begin
        cur_byte = {din, cur_byte[7:1]};
        bitn++; vlow++;
        if (bitn == 8) begin cur_bytes.push_back(cur_byte); bitn = 0; end
      end else begin
        stall++;
        if (!din) bad = 1'b1;
      end
      if (!frame_n) fnlow++;
      last_fn = frame_n;
      n_cyc++;
    end else begin
      if (!frame_n || !valid_n) idle_bad++;
      if (pkt_done != in_frame) idle_bad++;
      if (in_frame) begin
        fr_addr.push_back(cur_addr);
        fr_len.push_back(n_cyc);
        fr_nbytes.push_back(cur_bytes.size());
        fr_stall.push_back(stall);
        fr_fnlow.push_back(fnlow);
        fr_vlow.push_back(vlow);
        fr_ok.push_back(!bad && last_fn && (bitn == 0));
        foreach (cur_bytes[i]) rx_bytes.push_back(cur_bytes[i]);
        in_frame = 1'b0; n_cyc = 0; bitn = 0; stall = 0; fnlow = 0; vlow = 0;
        bad = 1'b0; cur_bytes.delete();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [3:0] a, input logic [7:0] d, input logic l);
    int w = 0;
    @(negedge clock);
    s_valid = 1'b1; s_addr = a; s_data = d; s_last = l;
    while (!s_ready && w < 2000) begin @(negedge clock); w++; end
    chk("push_accepted", 32'(s_ready), 32'd1);
    if (s_ready) exp_bytes.push_back(d);
    @(posedge clock);
    #1 s_valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [3:0] a, input int nexp, input bit stalled);
    int w = 0;
    while (fr_addr.size() <= fr_idx && w < 4000) begin @(negedge clock); w++; end
    chk("frame_seen", 32'(fr_addr.size() > fr_idx), 32'd1);
    if (fr_addr.size() > fr_idx) begin
      chk("frame_addr", 32'(fr_addr[fr_idx]), 32'(a));
      chk("frame_nbytes", fr_nbytes[fr_idx], nexp);
      chk("frame_protocol", 32'(fr_ok[fr_idx]), 32'd1);
      chk("frame_n_low", fr_fnlow[fr_idx], fr_len[fr_idx] - 1);
      chk("valid_n_low", fr_vlow[fr_idx], 8 * nexp);
      if (stalled) begin
        chk("stall_seen", 32'(fr_stall[fr_idx] > 0), 32'd1);
        chk("frame_len", fr_len[fr_idx], 4 + PAD + 8 * nexp + fr_stall[fr_idx]);
      end else begin
        chk("stall_none", fr_stall[fr_idx], 0);
        chk("frame_len", fr_len[fr_idx], 4 + PAD + 8 * nexp);
      end
      for (int i = 0; i < nexp; i++) begin
        if (exp_bytes.size() > 0 && rx_idx < rx_bytes.size()) begin
          chk("payload_byte", 32'(rx_bytes[rx_idx]), 32'(exp_bytes.pop_front()));
          rx_idx++;
        end
      end
      fr_idx++;
    end
  endtask

  logic [FRAME1-1:0] obs_din, obs_vn, obs_fn, e_din, e_vn, e_fn;
  logic [3:0]        m_addr;
  logic [7:0]        m_data;
  logic [3:0]        ra;
  int                k, rn;

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_addr = '0;
    dst_busy_n = '1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_din", 32'(din), 32'd0);
    chk("rst_valid_n", 32'(valid_n), 32'd1);
    chk("rst_frame_n", 32'(frame_n), 32'd1);
    chk("rst_tx_active", 32'(tx_active), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);

    // Single byte 0xA5 to port 5: exact wire sequence and latency.
    push_byte(4'd5, 8'hA5, 1'b1);
    k = 0;
    @(negedge clock);
    while (frame_n && k < 50) begin k++; @(negedge clock); end
    chk("start_latency", k, 3);
    m_addr = 4'd5; m_data = 8'hA5;
    for (int i = 0; i < FRAME1; i++) begin
      obs_din = {din, obs_din[FRAME1-1:1]};
      obs_vn  = {valid_n, obs_vn[FRAME1-1:1]};
      obs_fn  = {frame_n, obs_fn[FRAME1-1:1]};
      if (i < 4) begin
        e_din = {m_addr[0], e_din[FRAME1-1:1]}; m_addr = m_addr >> 1;
        e_vn  = {1'b1, e_vn[FRAME1-1:1]};
      end else if (i < 4 + PAD) begin
        e_din = {1'b1, e_din[FRAME1-1:1]};
        e_vn  = {1'b1, e_vn[FRAME1-1:1]};
      end else begin
        e_din = {m_data[0], e_din[FRAME1-1:1]}; m_data = m_data >> 1;
        e_vn  = {1'b0, e_vn[FRAME1-1:1]};
      end
      e_fn = {(i == FRAME1 - 1), e_fn[FRAME1-1:1]};
      if (i < FRAME1 - 1) @(negedge clock);
    end
    chk("a5_din_seq", 32'(obs_din), 32'(e_din));
    chk("a5_valid_n_seq", 32'(obs_vn), 32'(e_vn));
    chk("a5_frame_n_seq", 32'(obs_fn), 32'(e_fn));
    @(negedge clock);
    chk("a5_pkt_done", 32'(pkt_done), 32'd1);
    chk("a5_frame_n_after", 32'(frame_n), 32'd1);
    expect_frame(4'd5, 1, 1'b0);

    // Destination 3 busy for 20 cycles.
    dst_busy_n = 16'hFFF7;
    push_byte(4'd3, 8'h5A, 1'b1);
    k = 0;
    repeat (20) begin @(negedge clock); if (!frame_n) k++; end
    chk("busy_hold_frame_n", k, 0);
    dst_busy_n = 16'hFFFF;
    k = 0;
    @(negedge clock);
    while (frame_n && k < 50) begin k++; @(negedge clock); end
    chk("busy_release_latency", k, 1);
    expect_frame(4'd3, 1, 1'b0);

    // Three bytes with the last one late enough to force a stall.
    push_byte(4'd9, 8'h01, 1'b0);
    push_byte(4'd0, 8'h80, 1'b0);
    repeat (40) @(negedge clock);
    push_byte(4'd0, 8'hFF, 1'b1);
    expect_frame(4'd9, 3, 1'b1);

    // Ten bytes into an eight-deep FIFO while the port is busy.
    dst_busy_n = 16'hEFFF;
    for (int b = 0; b < 7; b++) push_byte(4'd12, 8'(8'h10 + b), 1'b0);
    chk("ready_before_full", 32'(s_ready), 32'd1);
    push_byte(4'd12, 8'h17, 1'b0);
    chk("ready_when_full", 32'(s_ready), 32'd0);
    dst_busy_n = 16'hFFFF;
    push_byte(4'd12, 8'h18, 1'b0);
    push_byte(4'd12, 8'h19, 1'b1);
    expect_frame(4'd12, 10, 1'b0);

    // Reset while bit 3 of the first data byte is on the wire.
    push_byte(4'd6, 8'h3C, 1'b0);
    push_byte(4'd6, 8'hC3, 1'b1);
    k = 0;
    while (valid_n && k < 200) begin @(negedge clock); k++; end
    chk("reached_data", 32'(valid_n), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_frame_n", 32'(frame_n), 32'd1);
    chk("midrst_valid_n", 32'(valid_n), 32'd1);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_tx_active", 32'(tx_active), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_bytes.delete();
    repeat (30) @(negedge clock);
    chk("midrst_flushed", fr_addr.size(), fr_idx);
    push_byte(4'd6, 8'h96, 1'b0);
    push_byte(4'd6, 8'h69, 1'b1);
    expect_frame(4'd6, 2, 1'b0);

    // Randomized packets; non-first entries carry a random, ignored address.
    for (int p = 0; p < 6; p++) begin
      ra = 4'($urandom_range(0, 15));
      rn = $urandom_range(1, 5);
      dst_busy_n = 16'($urandom) & ~(16'd1 << ra);
      for (int b = 0; b < rn; b++)
        push_byte((b == 0) ? ra : 4'($urandom), 8'($urandom), (b == rn - 1));
      repeat ($urandom_range(0, 10)) @(negedge clock);
      dst_busy_n = 16'hFFFF;
      expect_frame(ra, rn, 1'b0);
    end

    // Statistics after a fresh reset: packets of 1 and 4 bytes.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    exp_bytes.delete();
    push_byte(4'd1, 8'hE1, 1'b1);
    expect_frame(4'd1, 1, 1'b0);
    for (int b = 0; b < 4; b++) push_byte(4'd2, 8'($urandom), (b == 3));
    expect_frame(4'd2, 4, 1'b0);
    @(negedge clock);
`ifdef ROUTER_TX_STATS_EN
    chk("pkt_count", 32'(pkt_count), 32'd2);
    chk("byte_count", 32'(byte_count), 32'd5);
`else
    chk("pkt_count_off", 32'(pkt_count), 32'd0);
    chk("byte_count_off", 32'(byte_count), 32'd0);
`endif
    chk("idle_protocol", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
